// File: rtl/boreal_bus_arbiter.sv
// Two-master bus arbiter with gate priority, pub anti-starvation,
// and a downstream timeout that returns an error response.
module boreal_bus_arbiter #(
  parameter int TIMEOUT_CYC  = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pub_req,
  input  logic [68:0] pub_cmd,
  output logic [31:0] pub_rdata,
  output logic        pub_ack,
  output logic        pub_err,
  input  logic        gate_req,
  input  logic [68:0] gate_cmd,
  output logic [31:0] gate_rdata,
  output logic        gate_ack,
  output logic        gate_err,
  output logic        m_req,
  output logic [68:0] m_cmd,
  output logic        m_is_gate,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  input  logic        m_err,
  output logic        timeout_evt
);

  localparam logic [7:0] LP_TMO = 8'(TIMEOUT_CYC - 1);
  localparam logic [3:0] LP_STV = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_starve;
  logic [7:0]  r_wait;
  logic [68:0] r_cmd;
  logic        r_is_gate;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_tmo;

  logic w_any;
  logic w_pub_win;
  logic w_tmo;
  logic w_resp;

  assign w_any     = pub_req | gate_req;
  assign w_pub_win = pub_req & (~gate_req | (r_starve >= LP_STV));
  assign w_tmo     = (r_wait == LP_TMO);
  assign w_resp    = (r_state == S_RESP);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_XFER;
      S_XFER:  if (m_ack || w_tmo) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_starve  <= '0;
      r_wait    <= '0;
      r_cmd     <= '0;
      r_is_gate <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_cmd     <= w_pub_win ? pub_cmd : gate_cmd;
            r_is_gate <= ~w_pub_win;
            r_wait    <= '0;
            r_tmo     <= 1'b0;
            if (w_pub_win)
              r_starve <= '0;
            else if (pub_req && r_starve < LP_STV)
              r_starve <= r_starve + 4'd1;
          end
        end
        S_XFER: begin
          r_wait <= r_wait + 8'd1;
          // a late ack still beats the timeout in the same cycle
          if (m_ack) begin
            r_rdata <= m_rdata;
            r_err   <= m_err;
            r_tmo   <= 1'b0;
          end else if (w_tmo) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_tmo   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m_req       = (r_state == S_XFER);
    m_cmd       = r_cmd;
    m_is_gate   = r_is_gate;
    pub_ack     = w_resp & ~r_is_gate;
    gate_ack    = w_resp & r_is_gate;
    pub_rdata   = pub_ack ? r_rdata : '0;
    pub_err     = pub_ack & r_err;
    gate_rdata  = gate_ack ? r_rdata : '0;
    gate_err    = gate_ack & r_err;
    timeout_evt = w_resp & r_tmo;
  end

endmodule

// File: tb/tb_boreal_bus_arbiter.sv
// Scoreboard bench for boreal_bus_arbiter: directed transactions,
// a downstream responder model and a decoupled response monitor.
module tb_boreal_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pub_req = 1'b0;
  logic [68:0] pub_cmd = '0;
  logic [31:0] pub_rdata;
  logic        pub_ack;
  logic        pub_err;
  logic        gate_req = 1'b0;
  logic [68:0] gate_cmd = '0;
  logic [31:0] gate_rdata;
  logic        gate_ack;
  logic        gate_err;
  logic        m_req;
  logic [68:0] m_cmd;
  logic        m_is_gate;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic        m_err = 1'b0;
  logic        timeout_evt;

  boreal_bus_arbiter #(
    .TIMEOUT_CYC (64),
    .STARVE_LIMIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pub_req    (pub_req),
    .pub_cmd    (pub_cmd),
    .pub_rdata  (pub_rdata),
    .pub_ack    (pub_ack),
    .pub_err    (pub_err),
    .gate_req   (gate_req),
    .gate_cmd   (gate_cmd),
    .gate_rdata (gate_rdata),
    .gate_ack   (gate_ack),
    .gate_err   (gate_err),
    .m_req      (m_req),
    .m_cmd      (m_cmd),
    .m_is_gate  (m_is_gate),
    .m_rdata    (m_rdata),
    .m_ack      (m_ack),
    .m_err      (m_err),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          g;
    logic [68:0] cmd;
    int          dly;
    logic [31:0] mrd;
    logic        merr;
    logic [31:0] erd;
    logic        eerr;
    logic        etmo;
    int          elen;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_rst = 1'b0;
  bit stuck = 1'b0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic logic [68:0] mk(input logic wr,
                                     input logic [3:0] st,
                                     input logic [31:0] ad,
                                     input logic [31:0] wd);
    return {wr, st, ad, wd};
  endfunction

  task automatic push(input bit g, input logic [68:0] c,
                      input int dly, input logic [31:0] mrd,
                      input logic merr, input logic [31:0] erd,
                      input logic eerr, input logic etmo,
                      input int elen);
    exp_t e;
    e.g = g; e.cmd = c; e.dly = dly; e.mrd = mrd; e.merr = merr;
    e.erd = erd; e.eerr = eerr; e.etmo = etmo; e.elen = elen;
    exp_q.push_back(e);
  endtask

  // downstream responder: acks in XFER cycle 'dly' (0-based), -1 = never
  int w_s = 0;
  always @(negedge clk) begin
    if (m_req && exp_q.size() > 0) begin
      m_ack   = (exp_q[0].dly == w_s);
      m_rdata = exp_q[0].mrd;
      m_err   = exp_q[0].merr;
      w_s++;
    end else begin
      w_s     = 0;
      m_ack   = 1'b1;
      m_rdata = 32'hA5A5_A5A5;
      m_err   = 1'b1;
    end
  end

  // monitor
  bit prev_mreq = 1'b0;
  int xlen = 0;
  always @(negedge clk) begin
    exp_t e;
    if (m_req && !prev_mreq) begin
      xlen = 1;
      chk("xfer_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        chk("m_cmd", m_cmd, exp_q[0].cmd);
        chk("m_is_gate", m_is_gate, exp_q[0].g);
      end
    end else if (m_req) begin
      xlen++;
    end
    if (pub_ack || gate_ack) begin
      chk("ack_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("one_ack", pub_ack & gate_ack, 1'b0);
        chk("ack_owner", gate_ack, e.g);
        chk("rdata", e.g ? gate_rdata : pub_rdata, e.erd);
        chk("err", e.g ? gate_err : pub_err, e.eerr);
        chk("timeout_evt", timeout_evt, e.etmo);
        chk("mreq_len", xlen, e.elen);
        if (e.g) chk("pub_quiet", {pub_ack, pub_err, pub_rdata}, 0);
        else     chk("gate_quiet", {gate_ack, gate_err, gate_rdata}, 0);
      end
    end else begin
      if (prev_mreq && !m_req && exp_q.size() > 0)
        void'(exp_q.pop_front());
      chk("idle_quiet",
          {pub_rdata, pub_err, gate_rdata, gate_err, timeout_evt}, 0);
    end
    if (chk_rst)
      chk("reset_outs",
          {m_req, m_cmd, m_is_gate, pub_rdata, pub_ack, pub_err,
           gate_rdata, gate_ack, gate_err, timeout_evt}, 0);
    chk("wait_budget", stuck, 1'b0);
    prev_mreq = m_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int np, input int ng, input int budget);
    int lp = np;
    int lg = ng;
    int c = 0;
    pub_req  = (np > 0);
    gate_req = (ng > 0);
    while (c < budget && (exp_q.size() != 0 || lp > 0 || lg > 0)) begin
      step();
      if (pub_ack && lp > 0) begin
        lp--;
        if (lp == 0) pub_req = 1'b0;
      end
      if (gate_ack && lg > 0) begin
        lg--;
        if (lg == 0) gate_req = 1'b0;
      end
      c++;
    end
    if (c >= budget) begin
      stuck = 1'b1;
      pub_req = 1'b0;
      gate_req = 1'b0;
    end
    step();
  endtask

  initial begin
    logic [68:0] c;
    logic [68:0] cp;
    rst = 1'b1;
    step();
    chk_rst = 1'b1;
    step();
    rst = 1'b0;
    chk_rst = 1'b0;
    step();

    // simultaneous requests: gate first, then pub
    c  = mk(1'b0, 4'hF, 32'h0000_1000, 32'h0);
    cp = mk(1'b1, 4'h3, 32'h0000_2000, 32'hCAFE_0001);
    gate_cmd = c;
    pub_cmd  = cp;
    push(1, c, 2, 32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0, 1'b0, 3);
    push(0, cp, 0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1);
    run(1, 1, 50);

    // gate read
    c = mk(1'b0, 4'hF, 32'h0000_3000, 32'h0);
    gate_cmd = c;
    push(1, c, 1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2);
    run(0, 1, 50);

    // pub read that times out
    c = mk(1'b0, 4'hF, 32'h0000_4000, 32'h0);
    pub_cmd = c;
    push(0, c, -1, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 1'b1, 64);
    run(1, 0, 200);

    // ack in the last XFER cycle beats the timeout
    c = mk(1'b0, 4'h1, 32'h0000_4004, 32'h0);
    pub_cmd = c;
    push(0, c, 63, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 64);
    run(1, 0, 200);

    // starvation: G G G G P G P
    c  = mk(1'b1, 4'hC, 32'h0000_5000, 32'h7777_0000);
    cp = mk(1'b0, 4'hF, 32'h0000_6000, 32'h0);
    gate_cmd = c;
    pub_cmd  = cp;
    for (int i = 0; i < 4; i++)
      push(1, c, 0, 32'h100 + i, 1'b0, 32'h100 + i, 1'b0, 1'b0, 1);
    push(0, cp, 1, 32'h600D_0001, 1'b0, 32'h600D_0001, 1'b0, 1'b0, 2);
    push(1, c, 0, 32'h104, 1'b0, 32'h104, 1'b0, 1'b0, 1);
    push(0, cp, 0, 32'h600D_0002, 1'b0, 32'h600D_0002, 1'b0, 1'b0, 1);
    run(2, 5, 200);

    // reset during the 2nd XFER cycle: transfer discarded, no ack
    c = mk(1'b0, 4'hF, 32'h0000_7000, 32'h0);
    pub_cmd = c;
    push(0, c, -1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 64);
    pub_req = 1'b1;
    step();
    step();
    rst = 1'b1;
    pub_req = 1'b0;
    step();
    rst = 1'b0;
    chk_rst = 1'b1;
    step();
    chk_rst = 1'b0;
    repeat (4) step();

    // recovery after reset
    c = mk(1'b0, 4'hF, 32'h0000_8000, 32'h0);
    gate_cmd = c;
    push(1, c, 0, 32'h5555_AAAA, 1'b1, 32'h5555_AAAA, 1'b1, 1'b0, 1);
    run(0, 1, 50);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
